izh_neuron_scheduler: RTL and testbench

IZH_NEURON_SCHEDULER -- requirements
Module: izh_neuron_scheduler

---
 rtl/izh_pkg.sv | 23 ++
 rtl/izh_update_core.sv | 43 ++++
 rtl/izh_neuron_scheduler.sv | 160 ++++++++++++++++
 tb/tb_izh_neuron_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// Shared Q4.16 constants, reset values and scheduler state encoding for the
// time-multiplexed Izhikevich neuron scheduler.
package izh_pkg;

  localparam int W    = 20;
  localparam int FRAC = 16;

  localparam logic signed [W-1:0] A     = 20'sh0051E;
  localparam logic signed [W-1:0] B     = 20'sh03333;
  localparam logic signed [W-1:0] C     = 20'shF599A;
  localparam logic signed [W-1:0] D     = 20'sh0051E;
  localparam logic signed [W-1:0] PEAK  = 20'sh00000;
  localparam logic signed [W-1:0] C14   = 20'sh16666;
  localparam logic signed [W-1:0] V_RST = 20'shF8000;
  localparam logic signed [W-1:0] U_RST = 20'shFCCCD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/izh_update_core.sv
// Combinational single-step Izhikevich update in Q4.16; spiking neurons are
// reset to (C, u+D) instead of integrating. All arithmetic wraps.
module izh_update_core #(
  parameter int W = izh_pkg::W
) (
  input  logic signed [W-1:0] v_i,
  input  logic signed [W-1:0] u_i,
  input  logic signed [W-1:0] cur_i,
  output logic signed [W-1:0] v_o,
  output logic signed [W-1:0] u_o,
  output logic                spike_o
);
  import izh_pkg::*;

  // Full-width signed product truncated back to Q4.16 (wraps on overflow).
  function automatic logic signed [W-1:0] qmul(input logic signed [W-1:0] a,
                                               input logic signed [W-1:0] b);
    logic signed [2*W-1:0] ae;
    logic signed [2*W-1:0] be;
    logic signed [2*W-1:0] p;
    ae = {{W{a[W-1]}}, a};
    be = {{W{b[W-1]}}, b};
    p  = ae * be;
    return p[FRAC+W-1:FRAC];
  endfunction

  logic signed [W-1:0] dv_sum;
  logic signed [W-1:0] bv_minus_u;
  logic signed [W-1:0] v_int;
  logic signed [W-1:0] u_int;

  always_comb begin
    dv_sum     = qmul(v_i, v_i) + v_i + (v_i >>> 2) + (C14 >>> 2)
                 - (u_i >>> 2) + (cur_i >>> 2);
    v_int      = v_i + (dv_sum >>> 2);
    bv_minus_u = qmul(B, v_i) - u_i;
    u_int      = u_i + (qmul(A, bv_minus_u) >>> 4);
    spike_o    = (v_i > PEAK);
    v_o        = spike_o ? C : v_int;
    u_o        = spike_o ? (u_i + D) : u_int;
  end

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Sweeps N_NEURONS time-multiplexed Izhikevich neurons once per step_start and
// streams spike indices through a small FIFO. Define IZH_SPIKE_COUNT_EN to add spk_count.
module izh_neuron_scheduler #(
  parameter int N_NEURONS = 8,
  parameter int W         = izh_pkg::W,
  parameter int SPK_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step_start,
  output logic                         busy,
  output logic                         step_done,
  output logic [$clog2(N_NEURONS)-1:0] cur_idx,
  input  logic signed [W-1:0]          cur_I,
  input  logic                         ld_valid,
  input  logic [$clog2(N_NEURONS)-1:0] ld_idx,
  input  logic signed [W-1:0]          ld_v,
  input  logic signed [W-1:0]          ld_u,
  output logic                         spk_valid,
  input  logic                         spk_ready,
  output logic [$clog2(N_NEURONS)-1:0] spk_idx
`ifdef IZH_SPIKE_COUNT_EN
  ,
  output logic [$clog2(N_NEURONS):0]   spk_count
`endif
);
  import izh_pkg::*;

  localparam int IW = $clog2(N_NEURONS);
  localparam int PW = $clog2(SPK_DEPTH);

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic                busy_q;
  logic                done_q;
  logic signed [W-1:0] v_q [N_NEURONS];
  logic signed [W-1:0] u_q [N_NEURONS];
  logic [IW-1:0]       spk_mem_q [SPK_DEPTH];
  logic [PW-1:0]       wr_ptr_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [PW:0]         cnt_q;

  logic signed [W-1:0] v_d;
  logic signed [W-1:0] u_d;
  logic                spike;
  logic                fifo_full;
  logic                sweeping;
  logic                adv;
  logic                push;
  logic                pop;
  logic                last;

  izh_update_core #(.W(W)) u_core (
    .v_i    (v_q[idx_q]),
    .u_i    (u_q[idx_q]),
    .cur_i  (cur_I),
    .v_o    (v_d),
    .u_o    (u_d),
    .spike_o(spike)
  );

  // A spiking neuron waits while the FIFO is full, even if a pop happens this cycle.
  always_comb begin
    fifo_full = (cnt_q == (PW+1)'(SPK_DEPTH));
    sweeping  = (state_q == ST_SWEEP);
    adv       = sweeping && !(spike && fifo_full);
    push      = adv && spike;
    pop       = (cnt_q != '0) && spk_ready;
    last      = (idx_q == IW'(N_NEURONS - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (step_start && !ld_valid) begin
            state_q <= ST_SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (adv) begin
            if (last) begin
              state_q <= ST_DONE;
              idx_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) spk_mem_q[wr_ptr_q] <= idx_q;
  end

  // Neuron register file: reset restores resting state, host loads only when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        v_q[i] <= V_RST;
        u_q[i] <= U_RST;
      end
    end else if (state_q == ST_IDLE && ld_valid) begin
      v_q[ld_idx] <= ld_v;
      u_q[ld_idx] <= ld_u;
    end else if (adv) begin
      v_q[idx_q] <= v_d;
      u_q[idx_q] <= u_d;
    end
  end

`ifdef IZH_SPIKE_COUNT_EN
  logic [IW:0] sweep_cnt_q;
  logic [IW:0] spk_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_cnt_q <= '0;
      spk_count_q <= '0;
    end else begin
      if (state_q == ST_IDLE) sweep_cnt_q <= '0;
      else if (push)          sweep_cnt_q <= sweep_cnt_q + (IW+1)'(1);
      if (adv && last)        spk_count_q <= sweep_cnt_q + (IW+1)'(push);
    end
  end

  assign spk_count = spk_count_q;
`endif

  assign busy      = busy_q;
  assign step_done = done_q;
  assign cur_idx   = idx_q;
  assign spk_valid = (cnt_q != '0);
  assign spk_idx   = spk_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Directed bench for izh_neuron_scheduler: reset, plain sweep, single spike,
// FIFO back-pressure, mid-sweep reset and ignored/overridden starts.
module tb_izh_neuron_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_start = 1'b0;
  logic        busy;
  logic        step_done;
  logic [2:0]  cur_idx;
  logic [19:0] cur_I = '0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_idx = '0;
  logic [19:0] ld_v = '0;
  logic [19:0] ld_u = '0;
  logic        spk_valid;
  logic        spk_ready = 1'b1;
  logic [2:0]  spk_idx;
`ifdef IZH_SPIKE_COUNT_EN
  logic [3:0]  spk_count;
`endif

  izh_neuron_scheduler #(.N_NEURONS(8), .W(20), .SPK_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .step_start(step_start),
    .busy      (busy),
    .step_done (step_done),
    .cur_idx   (cur_idx),
    .cur_I     (cur_I),
    .ld_valid  (ld_valid),
    .ld_idx    (ld_idx),
    .ld_v      (ld_v),
    .ld_u      (ld_u),
    .spk_valid (spk_valid),
    .spk_ready (spk_ready),
    .spk_idx   (spk_idx)
`ifdef IZH_SPIKE_COUNT_EN
    ,
    .spk_count (spk_count)
`endif
  );

  always #5 clk = ~clk;

  // One step from (-0.5, -0.2) with I=0, worked by hand in Q4.16.
  localparam logic [19:0] V_RST  = 20'hF8000;
  localparam logic [19:0] U_RST  = 20'hFCCCD;
  localparam logic [19:0] V_STEP = 20'hF8199;
  localparam logic [19:0] U_STEP = 20'hFCCD5;
  localparam logic [19:0] V_C    = 20'hF599A;
  localparam logic [19:0] U_D    = 20'h0051E;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_n;
  int done_n;
  int ev_q[$];

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] v_of(input int i);
    return dut.v_q[i];
  endfunction

  function automatic logic [19:0] u_of(input int i);
    return dut.u_q[i];
  endfunction

  task automatic clear_mon();
    busy_n = 0;
    done_n = 0;
    ev_q.delete();
  endtask

  task automatic monitor(input int n);
    for (int k = 0; k < n; k++) begin
      busy_n += int'(busy);
      done_n += int'(step_done);
      if (spk_valid && spk_ready) ev_q.push_back(int'(spk_idx));
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic preload(input int idx, input logic [19:0] v, input logic [19:0] u);
    ld_valid = 1'b1;
    ld_idx   = 3'(idx);
    ld_v     = v;
    ld_u     = u;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic pulse_start();
    step_start = 1'b1;
    @(negedge clk);
    step_start = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", step_done, 0);
    chk_eq("rst_spk_valid", spk_valid, 0);
    chk_eq("rst_cur_idx", cur_idx, 0);
    chk_eq("rst_v0", v_of(0), V_RST);
    chk_eq("rst_u7", u_of(7), U_RST);
`ifdef IZH_SPIKE_COUNT_EN
    chk_eq("rst_spk_count", spk_count, 0);
`endif

    // Plain sweep from reset state, no current.
    clear_mon();
    pulse_start();
    monitor(20);
    chk_eq("sweep_busy_cycles", busy_n, 8);
    chk_eq("sweep_done_pulses", done_n, 1);
    chk_eq("sweep_spikes", ev_q.size(), 0);
    for (int i = 0; i < 8; i++) begin
      chk_eq($sformatf("sweep_v%0d", i), v_of(i), V_STEP);
      chk_eq($sformatf("sweep_u%0d", i), u_of(i), U_STEP);
    end

    // Single spiking neuron.
    do_reset();
    preload(3, 20'h00001, 20'h00000);
    chk_eq("ld_v3", v_of(3), 20'h00001);
    clear_mon();
    pulse_start();
    monitor(20);
    chk_eq("spk1_events", ev_q.size(), 1);
    chk_eq("spk1_idx", (ev_q.size() > 0) ? ev_q[0] : -1, 3);
    chk_eq("spk1_done", done_n, 1);
    chk_eq("spk1_v3", v_of(3), V_C);
    chk_eq("spk1_u3", u_of(3), U_D);
    chk_eq("spk1_v2", v_of(2), V_STEP);
`ifdef IZH_SPIKE_COUNT_EN
    chk_eq("spk1_count", spk_count, 1);
`endif
    clear_mon();
    pulse_start();
    monitor(20);
    chk_eq("spk2_events", ev_q.size(), 0);
`ifdef IZH_SPIKE_COUNT_EN
    chk_eq("spk2_count", spk_count, 0);
`endif

    // All neurons spike with the consumer stalled.
    do_reset();
    for (int i = 0; i < 8; i++) preload(i, 20'h00001, 20'h00000);
    spk_ready = 1'b0;
    clear_mon();
    pulse_start();
    monitor(10);
    chk_eq("stall_busy", busy, 1);
    chk_eq("stall_cur_idx", cur_idx, 4);
    chk_eq("stall_spk_valid", spk_valid, 1);
    chk_eq("stall_v4_held", v_of(4), 20'h00001);
    chk_eq("stall_v3_written", v_of(3), V_C);
    chk_eq("stall_no_done", done_n, 0);
    spk_ready = 1'b1;
    monitor(30);
    chk_eq("drain_events", ev_q.size(), 8);
    for (int i = 0; i < 8; i++)
      chk_eq($sformatf("drain_idx%0d", i), (ev_q.size() > i) ? ev_q[i] : -1, i);
    chk_eq("drain_done", done_n, 1);
    chk_eq("drain_empty", spk_valid, 0);
    chk_eq("drain_v7", v_of(7), V_C);
`ifdef IZH_SPIKE_COUNT_EN
    chk_eq("drain_count", spk_count, 8);
`endif

    // Reset in the middle of a sweep with a spike queued.
    do_reset();
    preload(0, 20'h00001, 20'h00000);
    spk_ready = 1'b0;
    clear_mon();
    pulse_start();
    monitor(3);
    chk_eq("mid_pre_valid", spk_valid, 1);
    chk_eq("mid_pre_idx", cur_idx, 3);
    reset = 1'b1;
    #1;
    chk_eq("mid_rst_busy", busy, 0);
    chk_eq("mid_rst_valid", spk_valid, 0);
    chk_eq("mid_rst_cur_idx", cur_idx, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_eq($sformatf("mid_v%0d", i), v_of(i), V_RST);
      chk_eq($sformatf("mid_u%0d", i), u_of(i), U_RST);
    end
    clear_mon();
    monitor(12);
    chk_eq("mid_no_done", done_n, 0);
    chk_eq("mid_no_busy", busy_n, 0);
    spk_ready = 1'b1;

    // Start while busy is dropped; start with a load is dropped, load applied.
    clear_mon();
    pulse_start();
    monitor(2);
    step_start = 1'b1;
    monitor(1);
    step_start = 1'b0;
    monitor(30);
    chk_eq("dup_busy_cycles", busy_n, 8);
    chk_eq("dup_done", done_n, 1);
    clear_mon();
    step_start = 1'b1;
    preload(5, 20'h12345, 20'h00ABC);
    step_start = 1'b0;
    monitor(12);
    chk_eq("ldpri_busy", busy_n, 0);
    chk_eq("ldpri_done", done_n, 0);
    chk_eq("ldpri_v5", v_of(5), 20'h12345);
    chk_eq("ldpri_u5", u_of(5), 20'h00ABC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
